// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: NOP encoding, instruction field positions
// and the instruction-type encoding seen by control_unit.
package fetch_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned TYPE_MSB = 31;
  localparam int unsigned TYPE_LSB = 30;
  localparam int unsigned FUNC_MSB = 29;
  localparam int unsigned FUNC_LSB = 25;
  localparam int unsigned TYPE_W   = TYPE_MSB - TYPE_LSB + 1;
  localparam int unsigned FUNC_W   = FUNC_MSB - FUNC_LSB + 1;

  typedef enum logic [TYPE_W-1:0] {
    TYPE_CTRL = 2'b00,
    TYPE_MEM  = 2'b01,
    TYPE_DATA = 2'b10,
    TYPE_NOP  = 2'b11
  } instr_type_e;

  // Type NOP, func 00000; never decodes as SI.
  localparam logic [INSTR_W-1:0] INSTR_NOP = 32'hC000_0000;

  function automatic logic [TYPE_W-1:0] instr_type(input logic [INSTR_W-1:0] instr);
    return instr[TYPE_MSB:TYPE_LSB];
  endfunction

  function automatic logic [FUNC_W-1:0] instr_func(input logic [INSTR_W-1:0] instr);
    return instr[FUNC_MSB:FUNC_LSB];
  endfunction

endpackage

// File: rtl/fetch_unit_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, clear (sync, wins over inc), inc, cnt (registered count).
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: generates the PC, addresses the synchronous
// instruction memory and registers the IF/ID word. Squashes on redirect,
// holds on stall and halts once the PC runs past the last memory word.
// Ports:
//   clk, rst (sync, active-high)
//   stall, redirect_en, redirect_pc      - hazard / jump-resolution inputs
//   imem_addr (comb, = next PC), imem_rdata (data for current pc_q)
//   if_id_instr, if_id_pc, if_id_valid   - IF/ID register
//   instruction_type, func               - decoded fields of if_id_instr
//   halted, fetch_cnt, bubble_cnt        - status and performance counters
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect_en,
  input  logic [ADDR_W-1:0]    redirect_pc,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0]   imem_rdata,
  output logic [INSTR_W-1:0]   if_id_instr,
  output logic [ADDR_W-1:0]    if_id_pc,
  output logic                 if_id_valid,
  output logic [TYPE_W-1:0]    instruction_type,
  output logic [FUNC_W-1:0]    func,
  output logic                 halted,
  output logic [CNT_W-1:0]     fetch_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(4 * (IMEM_DEPTH - 1));
  localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] WORD_MSK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              past_end;
  logic              fetch_inc;
  logic              bubble_inc;

  // Next-PC selection; the memory is addressed with pc_next so that
  // imem_rdata always belongs to pc_q in the following cycle.
  always_comb begin
    redirect_tgt = redirect_pc & WORD_MSK;
    past_end     = pc_q > LAST_PC;
    pc_next      = pc_q + PC_STEP;
    fetch_inc    = 1'b0;
    bubble_inc   = 1'b0;
    if (rst) begin
      pc_next = RST_PC;
    end else if (redirect_en) begin
      pc_next    = redirect_tgt;
      bubble_inc = 1'b1;
    end else if (stall || halted || past_end) begin
      // past_end also freezes the PC on the edge that enters halt.
      pc_next = pc_q;
    end else begin
      fetch_inc = 1'b1;
    end
  end

  assign imem_addr = pc_next;

  // PC and IF/ID register.
  always_ff @(posedge clk) begin
    pc_q <= pc_next;
    if (rst) begin
      if_id_instr <= INSTR_NOP;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (redirect_en) begin
      // Wrong-path word squashed; target arrives next cycle.
      if_id_instr <= INSTR_NOP;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (stall || halted) begin
      // Hold everything.
    end else if (past_end) begin
      if_id_instr <= INSTR_NOP;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      halted      <= 1'b1;
    end else begin
      if_id_instr <= imem_rdata;
      if_id_pc    <= pc_q;
      if_id_valid <= 1'b1;
    end
  end

  // Invalid slots carry INSTR_NOP, so these never show the SI encoding.
  assign instruction_type = instr_type(if_id_instr);
  assign func             = instr_func(if_id_instr);

  sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (fetch_inc),
    .cnt   (fetch_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (bubble_inc),
    .cnt   (bubble_cnt)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 256-word instance for run/stall/redirect/
// reset, and a 4-word instance with 2-bit counters for halt and saturation.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- main instance ----------------
  logic        rst, stall, redirect_en;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, if_id_instr, if_id_pc;
  logic        if_id_valid, halted;
  logic [1:0]  instruction_type;
  logic [4:0]  func;
  logic [15:0] fetch_cnt, bubble_cnt;
  logic [31:0] mem [256];

  fetch_unit #(.ADDR_W(32), .IMEM_DEPTH(256), .RESET_PC(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
    .instruction_type(instruction_type), .func(func), .halted(halted),
    .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
  );

  always_ff @(posedge clk) begin
    if (imem_addr < 32'd1024) imem_rdata <= mem[imem_addr[9:2]];
    else                      imem_rdata <= 32'h0;
  end

  // ---------------- 4-word instance ----------------
  logic        rst4, redirect_en4;
  logic [31:0] redirect_pc4, imem_addr4, imem_rdata4, if_id_instr4, if_id_pc4;
  logic        if_id_valid4, halted4;
  logic [1:0]  instruction_type4;
  logic [4:0]  func4;
  logic [1:0]  fetch_cnt4, bubble_cnt4;
  logic [31:0] mem4 [4];

  fetch_unit #(.ADDR_W(32), .IMEM_DEPTH(4), .RESET_PC(0), .CNT_W(2)) dut4 (
    .clk(clk), .rst(rst4), .stall(1'b0), .redirect_en(redirect_en4),
    .redirect_pc(redirect_pc4), .imem_addr(imem_addr4), .imem_rdata(imem_rdata4),
    .if_id_instr(if_id_instr4), .if_id_pc(if_id_pc4), .if_id_valid(if_id_valid4),
    .instruction_type(instruction_type4), .func(func4), .halted(halted4),
    .fetch_cnt(fetch_cnt4), .bubble_cnt(bubble_cnt4)
  );

  // Out-of-range reads return the SI encoding so a leak past halt shows up.
  always_ff @(posedge clk) begin
    if (imem_addr4 < 32'd16) imem_rdata4 <= mem4[imem_addr4[3:2]];
    else                     imem_rdata4 <= 32'h0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // IF/ID state of the main instance; invalid slots must read as NOP.
  task automatic chk_main(input string tag, input logic v, input logic [31:0] pc,
                          input int fn, input int fc, input int bc);
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(v));
    if (v) begin
      chk({tag, ".pc"},   if_id_pc, pc);
      chk({tag, ".type"}, 32'(instruction_type), 32'd2);
      chk({tag, ".func"}, 32'(func), 32'(fn));
    end else begin
      chk({tag, ".instr"}, if_id_instr, 32'hC000_0000);
      chk({tag, ".type"},  32'(instruction_type), 32'd3);
      chk({tag, ".func"},  32'(func), 32'd0);
    end
    chk({tag, ".fetch_cnt"},  32'(fetch_cnt), 32'(fc));
    chk({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'(bc));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {2'b10, 5'(i), 25'h0};
    for (int i = 0; i < 4; i++)   mem4[i] = {2'b10, 5'(i + 8), 25'h0};
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    rst4 = 1'b1; redirect_en4 = 1'b0; redirect_pc4 = '0;

    // Reset state
    tick(); tick();
    chk_main("reset", 1'b0, 0, 0, 0, 0);
    chk("reset.halted", 32'(halted), 32'd0);
    chk("reset.imem_addr", imem_addr, 32'h0);
    rst = 1'b0;

    // Free run: pcs 0,4,8 then stall with if_id_pc=8
    tick(); chk_main("run0", 1'b1, 32'h0, 0, 1, 0);
    tick(); chk_main("run1", 1'b1, 32'h4, 1, 2, 0);
    tick(); chk_main("run2", 1'b1, 32'h8, 2, 3, 0);
    stall = 1'b1;
    #1 chk("stall.imem_addr", imem_addr, 32'hC);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_main("stall", 1'b1, 32'h8, 2, 3, 0);
    end
    stall = 1'b0;
    tick(); chk_main("rel0", 1'b1, 32'hC, 3, 4, 0);
    tick(); chk_main("rel1", 1'b1, 32'h10, 4, 5, 0);

    // Redirect while if_id_pc=0x10; low target bits ignored
    redirect_en = 1'b1; redirect_pc = 32'h43;
    #1 chk("redir.imem_addr", imem_addr, 32'h40);
    tick(); chk_main("redir.bubble", 1'b0, 0, 0, 5, 1);
    redirect_en = 1'b0;
    tick(); chk_main("redir.tgt", 1'b1, 32'h40, 16, 6, 1);
    tick(); chk_main("redir.tgt4", 1'b1, 32'h44, 17, 7, 1);

    // Redirect together with stall: redirect wins
    redirect_en = 1'b1; redirect_pc = 32'h88; stall = 1'b1;
    tick(); chk_main("rs.bubble", 1'b0, 0, 0, 7, 2);
    redirect_en = 1'b0; stall = 1'b0;
    tick(); chk_main("rs.tgt", 1'b1, 32'h88, 2, 8, 2);

    // Back-to-back redirects: last target wins, one bubble each
    redirect_en = 1'b1; redirect_pc = 32'h100;
    tick(); chk_main("b2b.0", 1'b0, 0, 0, 8, 3);
    redirect_pc = 32'h20C;
    tick(); chk_main("b2b.1", 1'b0, 0, 0, 8, 4);
    redirect_en = 1'b0;
    tick(); chk_main("b2b.tgt", 1'b1, 32'h20C, 3, 9, 4);

    // Reset mid-run with stall and redirect pending
    rst = 1'b1; stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h80;
    #1 chk("rst2.imem_addr", imem_addr, 32'h0);
    tick(); chk_main("rst2", 1'b0, 0, 0, 0, 0);
    chk("rst2.halted", 32'(halted), 32'd0);
    rst = 1'b0; stall = 1'b0; redirect_en = 1'b0;
    tick(); chk_main("rst2.run", 1'b1, 32'h0, 0, 1, 0);

    // 4-word instance: run to halt, counter saturation, restart
    rst4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("h.valid", 32'(if_id_valid4), 32'd1);
      chk("h.pc", if_id_pc4, 32'(4 * i));
      chk("h.func", 32'(func4), 32'(i + 8));
      chk("h.fetch_cnt", 32'(fetch_cnt4), (i < 3) ? 32'(i + 1) : 32'd3);
      chk("h.halted", 32'(halted4), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("h.stop.halted", 32'(halted4), 32'd1);
      chk("h.stop.valid", 32'(if_id_valid4), 32'd0);
      chk("h.stop.type", 32'(instruction_type4), 32'd3);
      chk("h.stop.instr", if_id_instr4, 32'hC000_0000);
      chk("h.stop.bubble_cnt", 32'(bubble_cnt4), 32'd0);
      chk("h.stop.fetch_cnt", 32'(fetch_cnt4), 32'd3);
      chk("h.stop.imem_addr", imem_addr4, 32'h10);
    end
    redirect_en4 = 1'b1; redirect_pc4 = 32'h0;
    tick();
    chk("h.redir.halted", 32'(halted4), 32'd0);
    chk("h.redir.valid", 32'(if_id_valid4), 32'd0);
    chk("h.redir.bubble_cnt", 32'(bubble_cnt4), 32'd1);
    redirect_en4 = 1'b0;
    tick();
    chk("h.restart.valid", 32'(if_id_valid4), 32'd1);
    chk("h.restart.pc", if_id_pc4, 32'h0);
    chk("h.restart.func", 32'(func4), 32'd8);
    chk("h.restart.halted", 32'(halted4), 32'd0);
    tick();
    chk("h.restart.pc4", if_id_pc4, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
